// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS controller
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LH     = 6'b100001;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SH     = 6'b101001;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_STORE,
        CLS_BRANCH, CLS_JUMP, CLS_LINK, CLS_ILLEGAL
    } instr_class_t;

    localparam logic [1:0] NPC_SEQ    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JREG   = 2'b11;

    localparam logic [1:0] WD_ALU  = 2'b00;
    localparam logic [1:0] WD_MEM  = 2'b01;
    localparam logic [1:0] WD_LINK = 2'b10;

    localparam logic [1:0] WR_RT = 2'b00;
    localparam logic [1:0] WR_RD = 2'b01;
    localparam logic [1:0] WR_RA = 2'b10;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] MT_NONE = 2'b00;
    localparam logic [1:0] MT_BYTE = 2'b01;
    localparam logic [1:0] MT_HALF = 2'b10;
    localparam logic [1:0] MT_WORD = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;

endpackage

// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - controller <-> IR/datapath signal bundle
interface mc_controller_if #(
    parameter int ALU_OP_W = 3
);
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic                zero;
    logic                branch;
    logic                mem_ready;
    logic                ir_wr;
    logic                pc_wr;
    logic                rf_wr;
    logic                dm_wr;
    logic                dm_rd;
    logic [1:0]          npc_op;
    logic [1:0]          wd_sel;
    logic [1:0]          wr_sel;
    logic [1:0]          ext_op;
    logic [1:0]          mem_type;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src;
    logic                instr_done;
    logic                illegal;
    logic                mem_err;

    modport master (
        input  opcode, funct, zero, branch, mem_ready,
        output ir_wr, pc_wr, rf_wr, dm_wr, dm_rd, npc_op, wd_sel, wr_sel,
               ext_op, mem_type, alu_op, alu_src, instr_done, illegal, mem_err
    );

    modport slave (
        output opcode, funct, zero, branch, mem_ready,
        input  ir_wr, pc_wr, rf_wr, dm_wr, dm_rd, npc_op, wd_sel, wr_sel,
               ext_op, mem_type, alu_op, alu_src, instr_done, illegal, mem_err
    );
endinterface

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational opcode/funct classifier and static select decode
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t cls,
    output logic [2:0]   alu_op,
    output logic         alu_src,
    output logic [1:0]   ext_op,
    output logic [1:0]   mem_type,
    output logic [1:0]   wd_sel,
    output logic [1:0]   wr_sel
);

    always_comb begin
        cls      = CLS_ILLEGAL;
        alu_op   = ALU_ADD;
        alu_src  = 1'b0;
        ext_op   = EXT_ZERO;
        mem_type = MT_NONE;
        wd_sel   = WD_ALU;
        wr_sel   = WR_RT;
        case (opcode)
            OP_RTYPE: begin
                wr_sel = WR_RD;
                case (funct)
                    FN_ADDU: cls = CLS_ALU_R;
                    FN_SUBU: begin cls = CLS_ALU_R; alu_op = ALU_SUB; end
                    FN_AND:  begin cls = CLS_ALU_R; alu_op = ALU_AND; end
                    FN_OR:   begin cls = CLS_ALU_R; alu_op = ALU_OR;  end
                    FN_SLL:  begin cls = CLS_ALU_R; alu_op = ALU_SLL; end
                    FN_SLLV: begin cls = CLS_ALU_R; alu_op = ALU_SLL; end
                    FN_JR:   cls = CLS_JUMP;
                    FN_JALR: begin cls = CLS_LINK; wd_sel = WD_LINK; end
                    default: cls = CLS_ILLEGAL;
                endcase
            end
            OP_ORI:   begin cls = CLS_ALU_I; alu_op = ALU_OR; alu_src = 1'b1; end
            OP_LUI:   begin cls = CLS_ALU_I; alu_src = 1'b1; ext_op = EXT_LUI; end
            OP_ADDIU: begin cls = CLS_ALU_I; alu_src = 1'b1; ext_op = EXT_SIGN; end
            OP_LW, OP_LH, OP_LB: begin
                cls     = CLS_LOAD;
                alu_src = 1'b1;
                ext_op  = EXT_SIGN;
                wd_sel  = WD_MEM;
                mem_type = (opcode == OP_LW) ? MT_WORD :
                           (opcode == OP_LH) ? MT_HALF : MT_BYTE;
            end
            OP_SW, OP_SH, OP_SB: begin
                cls     = CLS_STORE;
                alu_src = 1'b1;
                ext_op  = EXT_SIGN;
                mem_type = (opcode == OP_SW) ? MT_WORD :
                           (opcode == OP_SH) ? MT_HALF : MT_BYTE;
            end
            OP_BEQ:    begin cls = CLS_BRANCH; alu_op = ALU_SUB; ext_op = EXT_SIGN; end
            OP_REGIMM: begin cls = CLS_LINK; ext_op = EXT_SIGN; wd_sel = WD_LINK; wr_sel = WR_RA; end
            OP_J:      cls = CLS_JUMP;
            OP_JAL:    begin cls = CLS_LINK; wd_sel = WD_LINK; wr_sel = WR_RA; end
            default:   cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle MIPS control FSM with memory wait/timeout and trap
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_OP_W    = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    mc_controller_if.master bus
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t          state;
    state_t          state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic            taken;
    logic            illegal_q;
    logic            mem_err_q;
    logic            timeout;

    instr_class_t    cls;
    logic [2:0]      dec_alu_op;
    logic            dec_alu_src;
    logic [1:0]      dec_ext_op;
    logic [1:0]      dec_mem_type;
    logic [1:0]      dec_wd_sel;
    logic [1:0]      dec_wr_sel;
    logic [2:0]      alu_sel;

    mc_decode u_decode (
        .opcode   (bus.opcode),
        .funct    (bus.funct),
        .cls      (cls),
        .alu_op   (dec_alu_op),
        .alu_src  (dec_alu_src),
        .ext_op   (dec_ext_op),
        .mem_type (dec_mem_type),
        .wd_sel   (dec_wd_sel),
        .wr_sel   (dec_wr_sel)
    );

    // A ready in the final allowed cycle takes priority over the timeout.
    assign timeout = (state == ST_MEM) && !bus.mem_ready &&
                     (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH:  state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = (cls == CLS_ILLEGAL) ? ST_TRAP : ST_EXEC;
            ST_EXEC: begin
                if (cls == CLS_BRANCH || cls == CLS_JUMP)     state_nxt = ST_FETCH;
                else if (cls == CLS_LOAD || cls == CLS_STORE) state_nxt = ST_MEM;
                else                                          state_nxt = ST_WB;
            end
            ST_MEM: begin
                if (bus.mem_ready) state_nxt = (cls == CLS_LOAD) ? ST_WB : ST_FETCH;
                else if (timeout)  state_nxt = ST_TRAP;
            end
            ST_WB:   state_nxt = ST_FETCH;
            ST_TRAP: state_nxt = ST_TRAP;
            default: state_nxt = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt  <= '0;
            taken     <= 1'b0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            if (state != ST_MEM)     wait_cnt <= '0;
            else if (!bus.mem_ready) wait_cnt <= wait_cnt + CNT_W'(1);
            if (state == ST_EXEC)    taken <= (bus.opcode == OP_REGIMM) && bus.branch;
            if (state == ST_DECODE && cls == CLS_ILLEGAL) illegal_q <= 1'b1;
            if (timeout)             mem_err_q <= 1'b1;
        end
    end

    always_comb begin
        bus.ir_wr      = 1'b0;
        bus.pc_wr      = 1'b0;
        bus.rf_wr      = 1'b0;
        bus.dm_wr      = 1'b0;
        bus.dm_rd      = 1'b0;
        bus.instr_done = 1'b0;
        bus.npc_op     = NPC_SEQ;
        bus.wd_sel     = WD_ALU;
        bus.wr_sel     = WR_RT;
        bus.ext_op     = EXT_ZERO;
        bus.mem_type   = MT_NONE;
        bus.alu_src    = 1'b0;
        alu_sel        = ALU_ADD;
        case (state)
            ST_FETCH: bus.ir_wr = 1'b1;
            ST_EXEC: begin
                alu_sel     = dec_alu_op;
                bus.alu_src = dec_alu_src;
                bus.ext_op  = dec_ext_op;
                if (cls == CLS_BRANCH || cls == CLS_JUMP) begin
                    bus.pc_wr      = 1'b1;
                    bus.instr_done = 1'b1;
                    if (cls == CLS_BRANCH) bus.npc_op = bus.zero ? NPC_BRANCH : NPC_SEQ;
                    else bus.npc_op = (bus.opcode == OP_J) ? NPC_JUMP : NPC_JREG;
                end
            end
            ST_MEM: begin
                bus.mem_type = dec_mem_type;
                bus.dm_rd    = (cls == CLS_LOAD);
                bus.dm_wr    = (cls == CLS_STORE);
                if (bus.mem_ready && cls == CLS_STORE) begin
                    bus.pc_wr      = 1'b1;
                    bus.instr_done = 1'b1;
                end
            end
            ST_WB: begin
                bus.rf_wr      = 1'b1;
                bus.pc_wr      = 1'b1;
                bus.instr_done = 1'b1;
                bus.wd_sel     = dec_wd_sel;
                bus.wr_sel     = dec_wr_sel;
                bus.mem_type   = dec_mem_type;
                if (cls == CLS_LINK) begin
                    if (bus.opcode == OP_JAL)         bus.npc_op = NPC_JUMP;
                    else if (bus.opcode == OP_REGIMM) bus.npc_op = taken ? NPC_BRANCH : NPC_SEQ;
                    else                              bus.npc_op = NPC_JREG;
                end
            end
            default: ;
        endcase
        // Reset kills enables combinationally so an in-flight DM access aborts at once.
        if (reset) begin
            bus.ir_wr      = 1'b0;
            bus.pc_wr      = 1'b0;
            bus.rf_wr      = 1'b0;
            bus.dm_wr      = 1'b0;
            bus.dm_rd      = 1'b0;
            bus.instr_done = 1'b0;
        end
    end

    assign bus.alu_op  = ALU_OP_W'(alu_sel);
    assign bus.illegal = illegal_q;
    assign bus.mem_err = mem_err_q;

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle MIPS control unit: a state machine that issues per-state datapath controls for the existing instruction subset (R-type addu/subu/and/or/sll/sllv/jr/jalr, ori, lui, addiu, lw/lh/lb, sw/sh/sb, beq, bltzal, j, jal). It sits between the instruction register and the shared datapath (PC, NPC, GRF, EXT, ALU, DM). It adds variable-latency data-memory handshaking, a memory timeout, and illegal-opcode trapping.

## Interface
- ALU_OP_W, 3, width of alu_op
- MEM_TIMEOUT, 15, max cycles waiting for mem_ready in MEM before trapping (1..255)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  6  IR[31:26], stable from the cycle after FETCH
- funct  in  6  IR[5:0]
- zero  in  1  ALU equality result, sampled in EXEC
- branch  in  1  bltzal condition (rs < 0), sampled in EXEC
- mem_ready  in  1  DM transaction complete, sampled only in MEM
- ir_wr, pc_wr, rf_wr, dm_wr, dm_rd  out  1 each  write/read enables
- npc_op, wd_sel, wr_sel, ext_op, mem_type  out  2 each  mux and format selects, same encodings as the single-cycle controller
- alu_op  out  ALU_OP_W  000 add, 001 sub, 010 and, 011 or, 100 shift-left
- alu_src  out  1  0 = rt, 1 = ext immediate
- instr_done  out  1  high in the last cycle of every retired instruction
- illegal  out  1  sticky; undefined opcode/funct trapped
- mem_err  out  1  sticky; MEM timeout trapped

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: ir_wr=1. Next state: DECODE.
- DECODE: no enables. The decoder classifies the instruction. An undefined opcode, or R-type with an undefined funct, goes to TRAP and sets illegal. Otherwise next state is EXEC.
- EXEC: drives alu_op, alu_src and ext_op per instruction.
  - beq, j, jr: pc_wr=1. npc_op is 01 if beq and zero, 10 for j, 11 for jr, else 00. instr_done=1. Next state: FETCH.
  - Loads/stores: next state MEM.
  - All other instructions: next state WB. bltzal latches branch into a taken flag here.
- MEM: mem_type held.
  - Loads drive dm_rd=1; stores drive dm_wr=1. The enable stays asserted until the cycle mem_ready=1.
  - A wait counter increments on each cycle with mem_ready=0. If it reaches MEM_TIMEOUT, go to TRAP and set mem_err.
  - When mem_ready=1, loads go to WB. Stores assert pc_wr (npc_op 00) and instr_done, then go to FETCH.
- WB: rf_wr=1 with wd_sel/wr_sel per instruction. pc_wr=1, instr_done=1, next state FETCH.
  - npc_op is 10 for jal, 11 for jalr, 01 for bltzal when the taken flag is set, else 00.
  - Link writes take the pre-update PC+4 because GRF and PC commit on the same edge.
  - bltzal writes $31 regardless of the branch outcome.
- TRAP: all enables 0, instr_done 0. Held until reset.
- Invariant: pc_wr is asserted exactly once per retired instruction, in its final state. rf_wr, dm_wr and pc_wr are never high in the same cycle except rf_wr+pc_wr in WB.
- Outputs are decoded from state and opcode/funct. Unused selects are driven to 0, never X.

## Timing
- Reset: state=FETCH, wait counter=0, taken flag=0, illegal=0, mem_err=0. While reset is high, all enables and instr_done are forced to 0.
- Reset asserted mid-instruction aborts it. Any in-progress dm_rd/dm_wr drops asynchronously, and no pc_wr or rf_wr occurs.
- Latency in cycles, with w = MEM cycles with mem_ready=0:
  - beq/j/jr: 3
  - ALU, lui and link instructions: 4
  - sw/sh/sb: 4+w
  - lw/lh/lb: 5+w
- mem_ready=1 on the first MEM cycle gives w=0. mem_ready outside MEM is ignored.
- Timeout: TRAP is entered on the edge ending the MEM_TIMEOUT-th consecutive not-ready cycle. A ready in that same cycle wins over the timeout.
- The wait counter clears on MEM entry, so it never wraps. It is sized to ceil(log2(MEM_TIMEOUT+1)).

## Structure
- Shared package mc_ctrl_pkg holds:
  - opcode and funct constants
  - the state enum (3 bits)
  - npc_op/wd_sel/wr_sel/ext_op/mem_type/alu_op encodings
  - the instruction-class enum (ALU_R, ALU_I, LOAD, STORE, BRANCH, JUMP, LINK, ILLEGAL)
- One combinational sub-module, mc_decode, maps opcode/funct to class, alu_op, ext_op, mem_type, wd_sel and wr_sel. The top level holds the FSM, the counter, the flags and the per-state enable gating.

## Test plan
- addu after reset → ir_wr in cycle 0; rf_wr=1, wr_sel=01, pc_wr=1 and instr_done in cycle 3; next cycle is FETCH.
- lw with mem_ready low for 3 cycles → dm_rd high for 4 MEM cycles, mem_type=11, rf_wr with wd_sel=01 in cycle 7.
- beq with zero=1, then with zero=0 → pc_wr in cycle 2 with npc_op 01, then 00; rf_wr and dm_wr never asserted.
- jal → WB asserts rf_wr, wr_sel=10, wd_sel=10 and npc_op=10 together; bltzal with branch=0 → rf_wr=1 and npc_op=00.
- sw with mem_ready held low, MEM_TIMEOUT=15 → after 15 MEM cycles: mem_err=1, state TRAP, dm_wr=0, pc_wr never asserted; reset clears mem_err.
- Opcode 6'b111111 → illegal=1 after DECODE, all enables 0 thereafter; reset asserted during a sw MEM wait → dm_wr drops immediately and state returns to FETCH.
